param_reg_file: RTL
===================

PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter N, default 4, giving the data width in bits of every register and data port.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of registers (power of two, at least 2).
REQ-003 SHALL have parameter AW, default 2, giving the address width; AW SHALL equal log2(DEPTH).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high; clears all registers.
REQ-007 wr_en  input  1  write request from the upstream N-bit move stage.
REQ-008 wr_addr  input  AW  destination register index.
REQ-009 wr_data  input  N  value produced by the move stage.
REQ-010 rd_addr_a  input  AW  read port A index.
REQ-011 rd_addr_b  input  AW  read port B index.
REQ-012 rd_data_a  output  N  port A data, combinational.
REQ-013 rd_data_b  output  N  port B data, combinational.
REQ-014 wr_count  output  8  count of accepted writes, registered.

Function
REQ-015 Write: when wr_en=1, wr_addr!=0 and reset=0 at a rising clk edge, register[wr_addr] SHALL load wr_data.
REQ-016 Register 0 SHALL be hardwired to zero; writes to address 0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-017 Read latency SHALL be zero cycles: rd_data_x = register[rd_addr_x], with register 0 read as all zeros.
REQ-018 Bypass: when wr_en=1 and wr_addr=rd_addr_x!=0 in the same cycle, rd_data_x SHALL equal wr_data, not the stale value.
REQ-019 Both read ports SHALL be independent; equal addresses on A and B SHALL return identical data.
REQ-020 wr_count SHALL increment by 1 on each accepted write (REQ-015) and wrap from 255 to 0.
REQ-021 Unaccepted cycles (wr_en=0, or wr_addr=0) SHALL leave all registers and wr_count unchanged.
REQ-022 Data SHALL be stored unmodified: no sign extension, truncation or bit reordering of wr_data.

Reset
REQ-023 While reset=1 at a rising clk edge, all registers SHALL become 0 and wr_count SHALL become 0.
REQ-024 Reset SHALL take priority over a simultaneous write: wr_en=1 during reset SHALL be ignored.
REQ-025 During reset, reads SHALL still be combinational; bypass SHALL be suppressed while reset=1.
REQ-026 A write in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-027 Defaults for N, DEPTH and AW SHALL live in the shared CPU constants package/header, not be duplicated locally.
REQ-028 Each storage word SHALL be one instance of sub-module param_reg (N-bit, synchronous reset, load enable), generated for indices 1..DEPTH-1.
REQ-029 Write decode, bypass muxing and wr_count SHALL reside in param_reg_file.

Verification
REQ-030 Reset then read all addresses -> rd_data_a and rd_data_b are 0 for every address, and wr_count is 0.
REQ-031 Write 4'hA to address 2, then read A=2 and B=2 next cycle -> both return 4'hA, and wr_count is 1.
REQ-032 Write 4'hF to address 0 -> reads of address 0 return 0, and wr_count is unchanged.
REQ-033 Hold register 3 at 4'h5, then in one cycle write 4'h9 to address 3 with rd_addr_a=3 -> rd_data_a is 4'h9 in that same cycle.
REQ-034 Assert reset together with wr_en=1, wr_addr=1, wr_data=4'h7 -> register 1 reads 0 afterwards, and wr_count is 0.
REQ-035 Perform 256 accepted writes -> wr_count wraps to 0; with N=8 and wr_data=8'hC3, readback is 8'hC3 exactly.

Source files
------------

// File: rtl/param_reg_file_pkg.sv
// Shared CPU constants for the register file: default geometry and the
// write-acceptance rule used by the write decode.
package param_reg_file_pkg;

    // Default data width of every register and data port.
    localparam int N_DEFAULT     = 4;
    // Default number of registers (power of two, at least 2).
    localparam int DEPTH_DEFAULT = 4;
    // Default address width, log2(DEPTH_DEFAULT).
    localparam int AW_DEFAULT    = 2;

    // Width of the accepted-write counter.
    localparam int CNT_W = 8;

    // A write is accepted only outside reset and never to the zero register.
    function automatic logic write_accepted(input logic en, input logic rst, input logic addr_nonzero);
        return en & ~rst & addr_nonzero;
    endfunction

endpackage

// File: rtl/param_reg_file_param_reg.sv
// One N-bit storage word with synchronous active-high reset and load enable.
module param_reg
    import param_reg_file_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_r;

    // Storage word: reset clears it, load captures d, otherwise it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= {N{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/param_reg_file.sv
// Two-read, one-write register file with hardwired-zero register 0,
// same-cycle write-to-read bypass and a wrapping accepted-write counter.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [N-1:0]     rd_data_a,
    output logic [N-1:0]     rd_data_b,
    output logic [CNT_W-1:0] wr_count
);

    logic [DEPTH-1:0][N-1:0] regs_s;
    logic                    accept_s;
    logic                    bypass_a_s;
    logic                    bypass_b_s;
    logic [N-1:0]            rd_a_s;
    logic [N-1:0]            rd_b_s;
    logic [CNT_W-1:0]        wr_count_r;

    assign accept_s = write_accepted(wr_en, reset, (wr_addr != {AW{1'b0}}));

    // Register 0 has no storage; it always reads as zero.
    assign regs_s[0] = {N{1'b0}};

    genvar i;
    generate
        for (i = 1; i < DEPTH; i = i + 1) begin : g_word
            logic load_s;
            assign load_s = accept_s && (wr_addr == AW'(i));
            param_reg #(.N(N)) u_word (
                .clk   (clk),
                .reset (reset),
                .load  (load_s),
                .d     (wr_data),
                .q     (regs_s[i])
            );
        end
    endgenerate

    // Bypass fires only for a live write to the same nonzero address outside reset.
    assign bypass_a_s = wr_en && !reset && (wr_addr == rd_addr_a) && (rd_addr_a != {AW{1'b0}});
    assign bypass_b_s = wr_en && !reset && (wr_addr == rd_addr_b) && (rd_addr_b != {AW{1'b0}});

    // Read port muxes: forward the incoming write data or return stored value.
    always_comb begin
        rd_a_s = {N{1'b0}};
        rd_b_s = {N{1'b0}};
        if (bypass_a_s) begin
            rd_a_s = wr_data;
        end else begin
            rd_a_s = regs_s[rd_addr_a];
        end
        if (bypass_b_s) begin
            rd_b_s = wr_data;
        end else begin
            rd_b_s = regs_s[rd_addr_b];
        end
    end

    assign rd_data_a = rd_a_s;
    assign rd_data_b = rd_b_s;

    // Accepted-write counter, wraps naturally from 255 to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            wr_count_r <= wr_count_r + 8'd1;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign wr_count = wr_count_r;

endmodule
